pacman_motion_ctrl: RTL
=======================

// Module: pacman_motion_ctrl
// PURPOSE
//  Upstream sequencer for the 5x5 sprite drawer. Holds Pac-Man's tile position, direction and
//  mouth frame; on each movement tick it issues an erase request (old tile, colour 000), updates
//  position, then a draw request (new tile, yellow). Drives the drawer's tile x/y, shape select,
//  colour and go inputs and paces itself on the drawer's busy flag. Screen grid: 32x24 tiles of 5x5 px.
// PARAMETERS
//  GRID_W    32  tiles per row; tile_x range 0..GRID_W-1
//  GRID_H    24  tiles per column; tile_y range 0..GRID_H-1
//  START_X   15  tile_x after reset
//  START_Y   12  tile_y after reset
//  MOVE_DIV  1   ticks per move step (1..15); 4-bit divider
//  COL_PAC   3'b110  sprite colour for draw passes
// PORTS
//  clock       in   1  system clock (CLOCK_50)
//  reset       in   1  asynchronous, active-high reset
//  tick        in   1  1-cycle frame pulse from rate divider
//  dir_in      in   2  requested direction: 00 right, 01 left, 10 up, 11 down
//  dir_valid   in   1  1 = latch dir_in into pending direction this cycle
//  blocked     in   1  maze wall ahead of current tile in pending direction; sampled in MOVE
//  draw_busy   in   1  drawer is plotting (high from accepting go until its 5x5 pass completes)
//  draw_go     out  1  request to drawer; held until draw_busy seen high
//  tile_x      out  5  tile column presented to drawer
//  tile_y      out  5  tile row presented to drawer
//  shape_sel   out  3  {dir[1:0], frame}; frame 0 = mouth open, 1 = closed
//  colour      out  3  colour to drawer: 000 on erase, COL_PAC on draw
//  overrun     out  1  sticky: tick arrived while not IDLE
// BEHAVIOUR
//  - Reset (async): state=DRAW_REQ, tile_x=START_X, tile_y=START_Y, dir=00, pend_dir=00, frame=0,
//    div_cnt=0, draw_go=0, colour=COL_PAC, overrun=0. Forces one initial sprite draw after reset.
//  - All outputs registered. States: IDLE, ERASE_REQ, ERASE_WAIT, MOVE, DRAW_REQ, DRAW_WAIT.
//  - IDLE: on tick, div_cnt increments; when div_cnt==MOVE_DIV-1 clear it and go ERASE_REQ.
//  - ERASE_REQ: colour=000, draw_go=1, tile/shape unchanged; on draw_busy=1 drop draw_go -> ERASE_WAIT.
//  - ERASE_WAIT: on draw_busy=0 -> MOVE.
//  - MOVE (1 cycle): dir<=pend_dir. If blocked=0: step tile one in dir, frame<=~frame. If blocked=1:
//    position and frame unchanged. -> DRAW_REQ.
//  - DRAW_REQ: colour=COL_PAC, draw_go=1; on draw_busy=1 drop draw_go -> DRAW_WAIT.
//  - DRAW_WAIT: on draw_busy=0 -> IDLE.
//  - Handshake: draw_go rises 1 cycle after entering a REQ state; tile_x/tile_y/shape_sel/colour are
//    stable from draw_go rise until draw_busy falls. Minimum tick-to-draw_go latency 2 cycles.
//  - dir_valid accepted in any state (pending only; dir changes only in MOVE); dir_valid in the MOVE
//    cycle itself is applied at the next move.
//  - tick outside IDLE: discarded, overrun<=1 (sticky until reset); div_cnt not advanced.
//  - Vertical edges: tile_y clamps at 0 and GRID_H-1 (treated as blocked, frame held).
//  - Reset mid-pass: immediate return to reset values; drawer's own reset owns its abort.
// CONFIGURATION
//  PACMAN_WRAP_EN defined: horizontal tunnel; right from GRID_W-1 -> 0, left from 0 -> GRID_W-1,
//    frame toggles as a normal step.
//  PACMAN_WRAP_EN undefined: tile_x clamps at 0 and GRID_W-1 (treated as blocked, frame held).
// TESTING
//  1 reset, draw_busy pulses 3 cycles per go -> one draw at (15,12), shape_sel=000, colour=110; then IDLE.
//  2 dir 00, tick -> erase at (15,12) colour 000, then draw at (16,12) shape_sel=001.
//  3 dir 10 at (15,0), tick -> tile_y stays 0, frame held, draw still issued with shape_sel=100.
//  4 at (31,5) dir 00, tick: WRAP_EN -> tile_x=0; without -> tile_x=31, frame held.
//  5 tick during DRAW_WAIT -> overrun=1, no extra move; stays 1 until reset.
//  6 MOVE_DIV=3, 3 ticks -> exactly one erase/draw pair; reset during ERASE_WAIT -> tile (15,12), draw_go=0.

Source files
------------

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man motion sequencer: erase old tile, step position, redraw, paced by the sprite drawer's busy flag.
// Optional horizontal tunnel wrap when PACMAN_WRAP_EN is defined; otherwise tile_x clamps at the edges.
module pacman_motion_ctrl #(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned START_X  = 15,
    parameter int unsigned START_Y  = 12,
    parameter int unsigned MOVE_DIV = 1,
    parameter logic [2:0]  COL_PAC  = 3'b110
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic [1:0] i_dir_in,
    input  logic       i_dir_valid,
    input  logic       i_blocked,
    input  logic       i_draw_busy,
    output logic       o_draw_go,
    output logic [4:0] o_tile_x,
    output logic [4:0] o_tile_y,
    output logic [2:0] o_shape_sel,
    output logic [2:0] o_colour,
    output logic       o_overrun
);

    localparam int unsigned XW = 5;
    localparam int unsigned YW = 5;
    localparam int unsigned DW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE_REQ, S_ERASE_WAIT, S_MOVE, S_DRAW_REQ, S_DRAW_WAIT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [XW-1:0] r_tile_x, w_tile_x_nxt;
    logic [YW-1:0] r_tile_y, w_tile_y_nxt;
    logic [1:0]    r_dir, w_dir_nxt, r_pend_dir, w_pend_dir_nxt;
    logic          r_frame, w_frame_nxt;
    logic [DW-1:0] r_div_cnt, w_div_cnt_nxt;
    logic          r_draw_go, w_draw_go_nxt;
    logic [2:0]    r_colour, w_colour_nxt;
    logic          r_overrun, w_overrun_nxt;
    logic          w_at_edge, w_step, w_div_hit;

    assign w_div_hit = (r_div_cnt == DW'(MOVE_DIV - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_DRAW_REQ;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (i_tick && w_div_hit) w_state_nxt = S_ERASE_REQ;
            S_ERASE_REQ:  if (i_draw_busy)         w_state_nxt = S_ERASE_WAIT;
            S_ERASE_WAIT: if (!i_draw_busy)        w_state_nxt = S_MOVE;
            S_MOVE:                                w_state_nxt = S_DRAW_REQ;
            S_DRAW_REQ:   if (i_draw_busy)         w_state_nxt = S_DRAW_WAIT;
            S_DRAW_WAIT:  if (!i_draw_busy)        w_state_nxt = S_IDLE;
            default:                               w_state_nxt = S_IDLE;
        endcase
    end

    // Screen edge in the pending direction counts as a wall
    always_comb begin
        w_at_edge = 1'b0;
        case (r_pend_dir)
`ifdef PACMAN_WRAP_EN
            2'b00: w_at_edge = 1'b0;
            2'b01: w_at_edge = 1'b0;
`else
            2'b00: w_at_edge = (r_tile_x == XW'(GRID_W - 1));
            2'b01: w_at_edge = (r_tile_x == '0);
`endif
            2'b10: w_at_edge = (r_tile_y == '0);
            default: w_at_edge = (r_tile_y == YW'(GRID_H - 1));
        endcase
        w_step = !i_blocked && !w_at_edge;
    end

    always_comb begin
        w_draw_go_nxt  = 1'b0;
        w_colour_nxt   = r_colour;
        w_div_cnt_nxt  = r_div_cnt;
        w_overrun_nxt  = r_overrun | (i_tick && (r_state != S_IDLE));
        w_pend_dir_nxt = i_dir_valid ? i_dir_in : r_pend_dir;
        w_dir_nxt      = r_dir;
        w_frame_nxt    = r_frame;
        w_tile_x_nxt   = r_tile_x;
        w_tile_y_nxt   = r_tile_y;
        case (r_state)
            S_IDLE: if (i_tick) w_div_cnt_nxt = w_div_hit ? '0 : r_div_cnt + DW'(1);
            S_ERASE_REQ: begin
                w_colour_nxt  = 3'b000;
                w_draw_go_nxt = !i_draw_busy;
            end
            S_MOVE: begin
                w_dir_nxt = r_pend_dir;
                if (w_step) begin
                    w_frame_nxt = ~r_frame;
                    case (r_pend_dir)
                        2'b00: w_tile_x_nxt = (r_tile_x == XW'(GRID_W - 1)) ? '0 : r_tile_x + XW'(1);
                        2'b01: w_tile_x_nxt = (r_tile_x == '0) ? XW'(GRID_W - 1) : r_tile_x - XW'(1);
                        2'b10: w_tile_y_nxt = r_tile_y - YW'(1);
                        default: w_tile_y_nxt = r_tile_y + YW'(1);
                    endcase
                end
            end
            S_DRAW_REQ: begin
                w_colour_nxt  = COL_PAC;
                w_draw_go_nxt = !i_draw_busy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tile_x   <= XW'(START_X);
            r_tile_y   <= YW'(START_Y);
            r_dir      <= 2'b00;
            r_pend_dir <= 2'b00;
            r_frame    <= 1'b0;
            r_div_cnt  <= '0;
            r_draw_go  <= 1'b0;
            r_colour   <= COL_PAC;
            r_overrun  <= 1'b0;
        end else begin
            r_tile_x   <= w_tile_x_nxt;
            r_tile_y   <= w_tile_y_nxt;
            r_dir      <= w_dir_nxt;
            r_pend_dir <= w_pend_dir_nxt;
            r_frame    <= w_frame_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_draw_go  <= w_draw_go_nxt;
            r_colour   <= w_colour_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign o_draw_go   = r_draw_go;
    assign o_tile_x    = r_tile_x;
    assign o_tile_y    = r_tile_y;
    assign o_shape_sel = {r_dir, r_frame};
    assign o_colour    = r_colour;
    assign o_overrun   = r_overrun;

endmodule
